agc_stim_gen: RTL

Test-stimulus transmitter for the AGC core. It produces signed 8-bit square-wave samples in a three-segment amplitude-step burst: low, then high, then low amplitude. Samples go out over a valid/ready handshake into the AGC sample input. The block is the source side of the AGC sample interface and is used for on-chip step-response characterisation of attack and decay behaviour.

---
 rtl/agc_stim_gen.sv | 75 +++++++
 1 files changed

// File: rtl/agc_stim_gen.sv
// agc_stim_gen: three-segment (low/high/low) square-wave step-burst source for the AGC sample input
module agc_stim_gen #(
  parameter int DATA_W = 8,
  parameter int HOLD_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [6:0]        amp_lo,
  input  logic [6:0]        amp_hi,
  input  logic [2:0]        period_log2,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, LOW1, HIGH, LOW2} state_t;
  state_t state, state_n;
  logic [6:0] lo_r, hi_r, phase;
  logic [2:0] plog_r;
  logic [HOLD_W-1:0] hold_r, seg_cnt;
  logic sign, done_n, xfer, seg_last, go, wrap;
  logic [DATA_W-1:0] mag;
  assign busy = state != IDLE;
  assign sample_valid = busy;
  assign xfer = busy & sample_ready;
  assign go = (state == IDLE) & start & !abort;
  assign seg_last = seg_cnt == hold_r - 1'b1;
  // phase is widened so a half-period of 128 can be matched
  assign wrap = ({1'b0, phase} + 8'd1) == (8'd1 << plog_r);
  assign mag = DATA_W'(state == HIGH ? hi_r : lo_r);
  assign sample_out = busy ? (sign ? -mag : mag) : '0;
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    if (busy && abort) state_n = IDLE;
    else if (go) state_n = LOW1;
    else if (xfer && seg_last) begin
      state_n = state == LOW1 ? HIGH : state == HIGH ? LOW2 : IDLE;
      done_n = state == LOW2;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      lo_r <= '0;
      hi_r <= '0;
      plog_r <= '0;
      hold_r <= '0;
      phase <= '0;
      sign <= 1'b0;
      seg_cnt <= '0;
    end else begin
      state <= state_n;
      done <= done_n;
      if (go) begin
        lo_r <= amp_lo;
        hi_r <= amp_hi;
        plog_r <= period_log2;
        hold_r <= hold_len == '0 ? HOLD_W'(1) : hold_len;
        phase <= '0;
        sign <= 1'b0;
        seg_cnt <= '0;
      end else if (xfer) begin
        phase <= wrap ? '0 : phase + 7'd1;
        sign <= sign ^ wrap;
        seg_cnt <= seg_last ? '0 : seg_cnt + 1'b1;
      end
    end
  end
endmodule
